// File: rtl/cpu16_core.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_core
// Description : Single-cycle 16-bit load/store CPU with 8 registers, a
//               16-opcode ISA, external combinational instruction ROM and
//               internal data RAM (async read, sync write).
//               Optional macro CPU_TRACE_EN enables a simulation-only trace.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu16_core #(
    parameter int          DMEM_AW  = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] InstrAddr,
    input  logic [15:0] InstrData,
    output logic [15:0] PC,
    output logic        Halted,
    output logic        DbgWrEn,
    output logic [2:0]  DbgWrReg,
    output logic [15:0] DbgWrData
);

    localparam int c_DMEM_DEPTH = 1 << DMEM_AW;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLT  = 4'h5, OP_SLL  = 4'h6, OP_SRL  = 4'h7,
        OP_ADDI = 4'h8, OP_LW   = 4'h9, OP_SW   = 4'hA, OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC, OP_LI   = 4'hD, OP_JMP  = 4'hE, OP_HALT = 4'hF
    } opcode_t;

    logic [15:0] r_pc;
    logic        r_halted;
    logic [15:0] r_regs [0:7];
    logic [15:0] r_dmem [0:c_DMEM_DEPTH-1];

    opcode_t      w_op;
    logic [2:0]   w_rd, w_rs, w_rt;
    logic [15:0]  w_imm6, w_imm9, w_imm12;
    logic [15:0]  w_rd_val, w_rs_val, w_rt_val;
    logic [DMEM_AW-1:0] w_ea;
    logic [15:0]  w_mem_rdata;
    logic         w_reg_we;
    logic         w_reg_we_eff;
    logic [15:0]  w_reg_wdata;
    logic         w_mem_we;
    logic [15:0]  w_pc_next;
    logic         w_halt_now;

    assign w_op    = opcode_t'(InstrData[15:12]);
    assign w_rd    = InstrData[11:9];
    assign w_rs    = InstrData[8:6];
    assign w_rt    = InstrData[5:3];
    assign w_imm6  = {{10{InstrData[5]}}, InstrData[5:0]};
    assign w_imm9  = {{7{InstrData[8]}}, InstrData[8:0]};
    assign w_imm12 = {4'h0, InstrData[11:0]};

    // R0 is hard-wired to zero on the read side; it is never written either.
    assign w_rd_val = (w_rd == 3'd0) ? 16'h0000 : r_regs[w_rd];
    assign w_rs_val = (w_rs == 3'd0) ? 16'h0000 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? 16'h0000 : r_regs[w_rt];

    // Only the low DMEM_AW bits of rs+imm6 matter, so the sum is formed at that width.
    assign w_ea        = w_rs_val[DMEM_AW-1:0] + w_imm6[DMEM_AW-1:0];
    assign w_mem_rdata = r_dmem[w_ea];

    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_wdata = 16'h0000;
        w_mem_we    = 1'b0;
        w_pc_next   = r_pc + 16'd1;
        w_halt_now  = 1'b0;
        case (w_op)
            OP_ADD:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val + w_rt_val; end
            OP_SUB:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val - w_rt_val; end
            OP_AND:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val & w_rt_val; end
            OP_OR:   begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val | w_rt_val; end
            OP_XOR:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val ^ w_rt_val; end
            OP_SLT:  begin
                w_reg_we    = 1'b1;
                w_reg_wdata = {15'd0, ($signed(w_rs_val) < $signed(w_rt_val))};
            end
            OP_SLL:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val << w_rt_val[3:0]; end
            OP_SRL:  begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val >> w_rt_val[3:0]; end
            OP_ADDI: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val + w_imm6; end
            OP_LW:   begin w_reg_we = 1'b1; w_reg_wdata = w_mem_rdata; end
            OP_SW:   w_mem_we = 1'b1;
            OP_BEQ:  if (w_rd_val == w_rs_val) w_pc_next = r_pc + 16'd1 + w_imm6;
            OP_BNE:  if (w_rd_val != w_rs_val) w_pc_next = r_pc + 16'd1 + w_imm6;
            OP_LI:   begin w_reg_we = 1'b1; w_reg_wdata = w_imm9; end
            OP_JMP:  w_pc_next = w_imm12;
            OP_HALT: begin w_pc_next = r_pc; w_halt_now = 1'b1; end
            default: ;
        endcase
        // Once halted the core is frozen: nothing retires until reset.
        if (r_halted) begin
            w_reg_we   = 1'b0;
            w_mem_we   = 1'b0;
            w_pc_next  = r_pc;
            w_halt_now = 1'b0;
        end
    end

    assign w_reg_we_eff = w_reg_we && (w_rd != 3'd0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            r_pc <= w_pc_next;
            if (w_halt_now) begin
                r_halted <= 1'b1;
            end
            if (w_reg_we_eff) begin
                r_regs[w_rd] <= w_reg_wdata;
            end
        end
    end

    // Data RAM keeps its contents across reset; only the write is gated.
    always_ff @(posedge Clock) begin
        if (!Reset && w_mem_we) begin
            r_dmem[w_ea] <= w_rd_val;
        end
    end

    assign InstrAddr = r_pc;
    assign PC        = r_pc;
    assign Halted    = r_halted;
    assign DbgWrEn   = w_reg_we_eff;
    assign DbgWrReg  = w_rd;
    assign DbgWrData = w_reg_wdata;

`ifdef CPU_TRACE_EN
    always @(posedge Clock) begin
        if (!Reset && !r_halted) begin
            $write("PC=%h INSTR=%h", r_pc, InstrData);
            if (w_reg_we_eff) $write(" R%0d=%h", w_rd, w_reg_wdata);
            if (w_mem_we) $write(" MEM[%h]=%h", w_ea, w_rd_val);
            $write("\n");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu16_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu16_core
// Description : Scoreboard bench for cpu16_core: an ISA-level model predicts
//               every retired instruction; a monitor compares DUT activity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu16_core;

    localparam logic [15:0] c_RESET_PC = 16'h0000;
    localparam logic [15:0] c_HALT     = 16'hF000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] InstrAddr, InstrData, PC, DbgWrData;
    logic        Halted, DbgWrEn;
    logic [2:0]  DbgWrReg;

    cpu16_core #(.DMEM_AW(8), .RESET_PC(c_RESET_PC)) dut (
        .Clock(Clock), .Reset(Reset), .InstrAddr(InstrAddr), .InstrData(InstrData),
        .PC(PC), .Halted(Halted), .DbgWrEn(DbgWrEn), .DbgWrReg(DbgWrReg),
        .DbgWrData(DbgWrData)
    );

    always #5 Clock = ~Clock;

    logic [15:0] rom [0:4095];
    assign InstrData = rom[InstrAddr[11:0]];

    typedef struct packed {
        logic [15:0] pc;
        logic        we;
        logic [2:0]  r;
        logic [15:0] d;
    } step_t;
    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } wr_t;

    step_t exp_q[$];
    wr_t   cap[$];
    logic [15:0] m_regs [0:7];
    logic [15:0] m_mem  [0:255];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    running = 1'b0;

    int dir_reg [15] = '{1, 2, 3, 4, 5, 7, 7, 7, 6, 6, 1, 1, 1, 1, 2};
    int dir_dat [15] = '{'h5, 'hFFFD, 'h2, 'hFFF8, 'h5, 'h82, 'h104, 'h105,
                         'hFFF8, 'h0, 'h3, 'h2, 'h1, 'h0, 'h1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int low6);
        logic [31:0] o, d, s, l;
        o = op; d = rd; s = rs; l = low6;
        return {o[3:0], d[2:0], s[2:0], l[5:0]};
    endfunction

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
        return enc(op, rd, rs, rt * 8);
    endfunction

    function automatic logic [15:0] enc_li(input int rd, input int imm);
        logic [31:0] d, l;
        d = rd; l = imm;
        return {4'hD, d[2:0], l[8:0]};
    endfunction

    function automatic logic [15:0] enc_jmp(input int target);
        logic [31:0] t;
        t = target;
        return {4'hE, t[11:0]};
    endfunction

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // ISA-level reference: walks the ROM and records each retirement.
    task automatic model_run(output logic [15:0] halt_pc);
        int pc, op, rd, rs, a, b, d, s6, res, nxt;
        bit we;
        logic [15:0] instr;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        pc = c_RESET_PC;
        halt_pc = 16'hFFFF;
        for (int step = 0; step < 3000; step++) begin
            instr = rom[pc % 4096];
            op = instr[15:12]; rd = instr[11:9]; rs = instr[8:6];
            a  = m_regs[rs]; b = m_regs[instr[5:3]]; d = m_regs[rd];
            s6 = sx(instr[5:0], 6);
            we = 1'b1; res = 0; nxt = (pc + 1) % 65536;
            case (op)
                0:  res = a + b;
                1:  res = a - b;
                2:  res = a & b;
                3:  res = a | b;
                4:  res = a ^ b;
                5:  res = (sx(a, 16) < sx(b, 16)) ? 1 : 0;
                6:  res = a << (b % 16);
                7:  res = a >> (b % 16);
                8:  res = a + s6;
                9:  res = m_mem[(a + s6) & 255];
                10: begin we = 1'b0; m_mem[(a + s6) & 255] = d[15:0]; end
                11: begin we = 1'b0; if (d == a) nxt = (pc + 1 + s6) & 65535; end
                12: begin we = 1'b0; if (d != a) nxt = (pc + 1 + s6) & 65535; end
                13: res = sx(instr[8:0], 9);
                14: begin we = 1'b0; nxt = instr[11:0]; end
                default: we = 1'b0;
            endcase
            if (rd == 0) we = 1'b0;
            res = res & 65535;
            if (we) m_regs[rd] = res[15:0];
            exp_q.push_back({pc[15:0], we, rd[2:0], we ? res[15:0] : 16'h0});
            if (op == 15) begin
                halt_pc = pc[15:0];
                return;
            end
            pc = nxt;
        end
    endtask

    // Monitor: every non-halted cycle retires exactly one predicted step.
    always @(negedge Clock) begin
        step_t s;
        if (running && !Reset && !Halted) begin
            if (DbgWrEn) cap.push_back({DbgWrReg, DbgWrData});
            if (exp_q.size() == 0) begin
                fail_now("unexpected_retire");
            end else begin
                s = exp_q.pop_front();
                check("pc", {16'h0, PC}, {16'h0, s.pc});
                check("instr_addr", {16'h0, InstrAddr}, {16'h0, s.pc});
                check("wr_en", {31'h0, DbgWrEn}, {31'h0, s.we});
                if (s.we && DbgWrEn) check("wr_reg_data", {13'h0, DbgWrReg, DbgWrData}, {13'h0, s.r, s.d});
            end
        end
    end

    task automatic run_prog(input int budget, output logic [15:0] hpc);
        int cyc;
        exp_q.delete();
        cap.delete();
        model_run(hpc);
        @(posedge Clock); #1;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_pc", {16'h0, PC}, {16'h0, c_RESET_PC});
        check("reset_halted", {31'h0, Halted}, 32'h0);
        check("reset_instr_addr", {16'h0, InstrAddr}, {16'h0, c_RESET_PC});
        Reset   = 1'b0;
        running = 1'b1;
        cyc = 0;
        while (!Halted && cyc < budget) begin
            @(posedge Clock); #1;
            cyc++;
        end
        if (!Halted) fail_now("halt_timeout");
        for (int i = 0; i < 10; i++) begin
            check("halt_freeze", {14'h0, Halted, DbgWrEn, PC}, {14'h0, 1'b1, 1'b0, hpc});
            @(posedge Clock); #1;
        end
        running = 1'b0;
        check("steps_left", exp_q.size(), 32'h0);
    endtask

    initial begin
        logic [15:0] hpc;
        int op;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;

        // Fill the whole data RAM with its own address (exercises a BNE loop too).
        for (int i = 0; i < 4096; i++) rom[i] = c_HALT;
        rom[0] = enc_li(1, 255);
        rom[1] = enc(10, 1, 1, 0);
        rom[2] = enc(8, 1, 1, -1);
        rom[3] = enc(12, 1, 0, -3);
        rom[4] = enc(10, 0, 0, 0);
        run_prog(1500, hpc);

        // Directed program covering ALU, memory, R0, loop and JMP/HALT.
        for (int i = 0; i < 4096; i++) rom[i] = c_HALT;
        rom[0]  = enc_li(1, 5);
        rom[1]  = enc_li(2, -3);
        rom[2]  = enc_r(0, 3, 1, 2);
        rom[3]  = enc_r(1, 4, 2, 1);
        rom[4]  = enc(10, 1, 0, 10);
        rom[5]  = enc(9, 5, 0, 10);
        rom[6]  = enc(10, 4, 0, 5);
        rom[7]  = enc_li(7, 'h82);
        rom[8]  = enc_r(0, 7, 7, 7);
        rom[9]  = enc(8, 7, 7, 1);
        rom[10] = enc(9, 6, 7, 0);
        rom[11] = enc(8, 0, 0, 7);
        rom[12] = enc_r(0, 6, 0, 0);
        rom[13] = enc_li(1, 3);
        rom[14] = enc(8, 1, 1, -2 + 1);
        rom[15] = enc(12, 1, 0, -2);
        rom[16] = enc_li(2, 1);
        rom[17] = enc_jmp('h20);
        run_prog(200, hpc);
        check("directed_halt_pc", {16'h0, PC}, 32'h20);
        if (cap.size() != 15) begin
            check("directed_write_count", cap.size(), 32'd15);
        end else begin
            for (int i = 0; i < 15; i++) begin
                check("directed_write", {13'h0, cap[i].r, cap[i].d}, (dir_reg[i] << 16) | dir_dat[i]);
            end
        end

        // Random straight-line programs with forward-only control flow.
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 4096; i++) rom[i] = c_HALT;
            for (int i = 1; i < 8; i++) rom[i - 1] = enc_li(i, $urandom_range(0, 511));
            for (int i = 7; i < 40; i++) begin
                op = $urandom_range(0, 14);
                if (op == 11 || op == 12)
                    rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5));
                else if (op == 13)
                    rom[i] = enc_li($urandom_range(0, 7), $urandom_range(0, 511));
                else if (op == 14)
                    rom[i] = enc_jmp(i + 1 + $urandom_range(0, 3));
                else
                    rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
            end
            run_prog(200, hpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
